// File: rtl/conway_engine.sv
// rtl/conway_engine.sv - Game-of-Life engine with run/step/load control and halt detection
// Define CONWAY_WRAP_EN for a toroidal board; otherwise cells beyond the edge are dead.
module conway_engine #(
   parameter int W  = 16,
   parameter int H  = 16,
   parameter int GW = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            load,
   input  logic [W*H-1:0]  seed,
   input  logic            run,
   input  logic            step,
   input  logic [GW-1:0]   max_gen,
   output logic [W*H-1:0]  cells,
   output logic [GW-1:0]   gen_count,
   output logic            busy,
   output logic            still,
   output logic            extinct,
   output logic            done
);
   localparam int N  = W * H;
   localparam int IW = $clog2(N);

   typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

   state_t        state, state_next;
   logic [N-1:0]  next_cells;
   logic [GW-1:0] gen_inc;
   logic          next_still;
   logic          halt;
   logic          evolve;

   // Row 0 / column 0 sit at the MSB end of the flat vector.
   function automatic logic cell_at(input logic [N-1:0] b, input int rr, input int cc);
      int r2;
      int c2;
`ifdef CONWAY_WRAP_EN
      r2 = (rr + H) % H;
      c2 = (cc + W) % W;
`else
      if (rr < 0 || rr >= H || cc < 0 || cc >= W) return 1'b0;
      r2 = rr;
      c2 = cc;
`endif
      return b[IW'(N - 1 - (r2 * W + c2))];
   endfunction

   function automatic logic next_bit(input logic [N-1:0] b, input int r, input int c);
      logic [3:0] cnt;
      cnt = 4'd0;
      for (int dr = -1; dr <= 1; dr++) begin
         for (int dc = -1; dc <= 1; dc++) begin
            if (dr != 0 || dc != 0) cnt = cnt + {3'b000, cell_at(b, r + dr, c + dc)};
         end
      end
      return (cnt == 4'd3) || (cell_at(b, r, c) && cnt == 4'd2);
   endfunction

   for (genvar r = 0; r < H; r++) begin : g_row
      for (genvar c = 0; c < W; c++) begin : g_col
         assign next_cells[N-1-(r*W+c)] = next_bit(cells, r, c);
      end
   end

   // Halt is judged on the generation about to be written, so done rises with it.
   assign gen_inc    = (&gen_count) ? gen_count : gen_count + GW'(1);
   assign next_still = (next_cells == cells);
   assign halt       = next_still || (next_cells == '0) ||
                       ((max_gen != '0) && (gen_inc == max_gen));
   assign extinct    = (cells == '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (load) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE: if (run || step) state_next = halt ? HALT : (run ? RUN : IDLE);
            RUN:  if (!run) state_next = IDLE;
                  else if (halt) state_next = HALT;
            HALT: state_next = HALT;
            default: state_next = IDLE;
         endcase
      end
   end

   always_comb begin
      evolve = !load && (((state == IDLE) && (run || step)) || ((state == RUN) && run));
      busy   = (state == RUN);
      done   = (state == HALT);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cells     <= '0;
         gen_count <= '0;
         still     <= 1'b0;
      end else if (load) begin
         cells     <= seed;
         gen_count <= '0;
         still     <= 1'b0;
      end else if (evolve) begin
         cells     <= next_cells;
         gen_count <= gen_inc;
         still     <= next_still;
      end
   end
endmodule

// File: tb/tb_conway_engine.sv
// tb/tb_conway_engine.sv - bench for conway_engine against a 2-D array life model
module tb_conway_engine;
   localparam int W  = 16;
   localparam int H  = 16;
   localparam int GW = 16;
   localparam int N  = W * H;

   logic          clk = 1'b0;
   logic          reset, load, run, step;
   logic [N-1:0]  seed;
   logic [GW-1:0] max_gen;
   logic [N-1:0]  cells;
   logic [GW-1:0] gen_count;
   logic          busy, still, extinct, done;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   conway_engine #(.W(W), .H(H), .GW(GW)) dut (
      .clk(clk), .reset(reset), .load(load), .seed(seed), .run(run), .step(step),
      .max_gen(max_gen), .cells(cells), .gen_count(gen_count), .busy(busy),
      .still(still), .extinct(extinct), .done(done)
   );

   // Model state: board as a 2-D array; state 0=idle, 1=run, 2=halt.
   bit mb [H][W];
   int m_gen;
   bit m_still;
   int m_state;

   function automatic logic [N-1:0] pt(input int r, input int c);
      logic [N-1:0] f;
      f = '0;
      f[W*(H-r)-1-c] = 1'b1;
      return f;
   endfunction

   function automatic logic [N-1:0] model_flat();
      logic [N-1:0] f;
      f = '0;
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            f[W*(H-r)-1-c] = mb[r][c];
      return f;
   endfunction

   function automatic int alive(input int r, input int c);
`ifdef CONWAY_WRAP_EN
      return int'(mb[(r+H)%H][(c+W)%W]);
`else
      if (r < 0 || r >= H || c < 0 || c >= W) return 0;
      return int'(mb[r][c]);
`endif
   endfunction

   task automatic model_reset();
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            mb[r][c] = 1'b0;
      m_gen = 0; m_still = 1'b0; m_state = 0;
   endtask

   task automatic model_evolve(input logic [GW-1:0] mg);
      bit nb [H][W];
      int n;
      bit same;
      bit any;
      same = 1'b1; any = 1'b0;
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) begin
            n = 0;
            for (int dr = -1; dr <= 1; dr++)
               for (int dc = -1; dc <= 1; dc++)
                  if (dr != 0 || dc != 0) n += alive(r + dr, c + dc);
            nb[r][c] = (n == 3) || (mb[r][c] && n == 2);
         end
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) begin
            if (nb[r][c] != mb[r][c]) same = 1'b0;
            if (nb[r][c]) any = 1'b1;
            mb[r][c] = nb[r][c];
         end
      m_still = same;
      if (m_gen < (2**GW) - 1) m_gen++;
      if (same || !any || (mg != 0 && m_gen == int'(mg))) m_state = 2;
   endtask

   task automatic model_clock(input bit ld, input logic [N-1:0] s, input bit rn,
                              input bit st, input logic [GW-1:0] mg);
      if (ld) begin
         for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
               mb[r][c] = s[W*(H-r)-1-c];
         m_gen = 0; m_still = 1'b0; m_state = 0;
      end else if (m_state == 0 && (rn || st)) begin
         m_state = rn ? 1 : 0;
         model_evolve(mg);
      end else if (m_state == 1) begin
         if (rn) model_evolve(mg);
         else    m_state = 0;
      end
   endtask

   task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".cells"},   cells,        model_flat());
      check({tag, ".gen"},     N'(gen_count), N'(m_gen));
      check({tag, ".still"},   N'(still),     N'(m_still));
      check({tag, ".extinct"}, N'(extinct),   N'(model_flat() == '0));
      check({tag, ".busy"},    N'(busy),      N'(m_state == 1));
      check({tag, ".done"},    N'(done),      N'(m_state == 2));
   endtask

   task automatic cyc(input bit ld, input logic [N-1:0] s, input bit rn, input bit st,
                      input logic [GW-1:0] mg, input string tag);
      load = ld; seed = s; run = rn; step = st; max_gen = mg;
      @(posedge clk);
      model_clock(ld, s, rn, st, mg);
      #1;
      check_all(tag);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, ".cells"},   cells,         '0);
      check({tag, ".gen"},     N'(gen_count), '0);
      check({tag, ".still"},   N'(still),     '0);
      check({tag, ".busy"},    N'(busy),      '0);
      check({tag, ".done"},    N'(done),      '0);
      check({tag, ".extinct"}, N'(extinct),   N'(1));
   endtask

   function automatic logic [N-1:0] rand_seed();
      logic [N-1:0] f;
      for (int i = 0; i < N; i++) f[i] = ($urandom_range(0, 2) == 0);
      return f;
   endfunction

   logic [N-1:0] blk_h, blk_v, blk2, glider, r0, saved, s;
   logic [GW-1:0] mg;
   bit ld, rn, st;

   initial begin
      reset = 1'b1; load = 1'b0; run = 1'b0; step = 1'b0; seed = '0; max_gen = '0;
      model_reset();
      @(posedge clk); @(posedge clk); #1;
      check_reset_values("reset");
      reset = 1'b0;

      blk_h  = pt(5,5) | pt(5,6) | pt(5,7);
      blk_v  = pt(4,6) | pt(5,6) | pt(6,6);
      blk2   = pt(2,2) | pt(2,3) | pt(3,2) | pt(3,3);
      glider = pt(0,1) | pt(1,2) | pt(2,0) | pt(2,1) | pt(2,2);
      r0     = pt(0,5) | pt(0,6) | pt(0,7);

      // Blinker stepped three times
      cyc(1, blk_h, 0, 0, '0, "bl_load");
      check("bl_load_seed", cells, blk_h);
      cyc(0, '0, 0, 1, '0, "bl_s1");
      check("bl_s1_vert", cells, blk_v);
      cyc(0, '0, 0, 0, '0, "bl_idle");
      cyc(0, '0, 0, 1, '0, "bl_s2");
      check("bl_s2_horiz", cells, blk_h);
      cyc(0, '0, 0, 1, '0, "bl_s3");
      check("bl_s3_vert", cells, blk_v);
      check("bl_gen3", N'(gen_count), N'(3));
      check("bl_busy0", N'(busy), '0);

      // Still life halts, then ignores run/step until load
      cyc(1, blk2, 0, 0, '0, "blk_load");
      cyc(0, '0, 1, 0, '0, "blk_run");
      check("blk_still", N'(still), N'(1));
      check("blk_done", N'(done), N'(1));
      check("blk_gen1", N'(gen_count), N'(1));
      for (int i = 0; i < 3; i++) cyc(0, '0, 1, 0, '0, "blk_hold_run");
      for (int i = 0; i < 2; i++) cyc(0, '0, 0, 1, '0, "blk_hold_step");
      check("blk_gen_held", N'(gen_count), N'(1));
      cyc(1, glider, 1, 1, '0, "blk_reload");
      check("blk_reload_done", N'(done), '0);
      check("blk_reload_gen", N'(gen_count), '0);

      // Glider with generation limit 5
      for (int i = 0; i < 20 && !done; i++) cyc(0, '0, 1, 0, GW'(5), "gl5_run");
      check("gl5_done", N'(done), N'(1));
      check("gl5_gen", N'(gen_count), N'(5));
      saved = cells;
      for (int i = 0; i < 10; i++) cyc(0, '0, 1, 0, GW'(5), "gl5_hold");
      check("gl5_frozen", cells, saved);

      // Blinker on the top edge
      cyc(1, r0, 0, 0, '0, "r0_load");
`ifdef CONWAY_WRAP_EN
      for (int i = 0; i < 20; i++) cyc(0, '0, 1, 0, '0, "r0_wrap_run");
      check("r0_wrap_nohalt", N'(done), '0);
`else
      cyc(0, '0, 0, 1, '0, "r0_s1");
      check("r0_gen1", cells, pt(0,6) | pt(1,6));
      cyc(0, '0, 0, 1, '0, "r0_s2");
      check("r0_extinct", N'(extinct), N'(1));
      check("r0_done", N'(done), N'(1));
`endif

      // Free-running glider for 64 generations
      cyc(1, glider, 0, 0, '0, "glf_load");
      for (int i = 0; i < 64; i++) cyc(0, '0, 1, 0, '0, "glf_run");
`ifdef CONWAY_WRAP_EN
      check("glf_cells64", cells, glider);
      check("glf_gen64", N'(gen_count), N'(64));
      check("glf_done", N'(done), '0);
`endif

      // Asynchronous reset in the middle of a run
      cyc(1, rand_seed(), 0, 0, '0, "rst_load");
      for (int i = 0; i < 4; i++) cyc(0, '0, 1, 0, '0, "rst_run");
      #2 reset = 1'b1; run = 1'b0;
      #1 check_reset_values("rst_async");
      model_reset();
      @(posedge clk); #1 reset = 1'b0;
      check_all("rst_after");

      // Randomised control with random seeds
      for (int k = 0; k < 30; k++) begin
         mg = ($urandom_range(0, 1) == 0) ? '0 : GW'($urandom_range(1, 12));
         cyc(1, rand_seed(), 0, 0, mg, "rnd_load");
         for (int j = 0; j < 15; j++) begin
            ld = ($urandom_range(0, 31) == 0);
            rn = ($urandom_range(0, 9) < 7);
            st = ($urandom_range(0, 4) == 0);
            s  = rand_seed();
            cyc(ld, s, rn, st, mg, "rnd");
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
